// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle signed/unsigned multiply/divide unit owning HI/LO.
// One radix-2 iteration per clock; sign correction in a final FIX cycle.
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [ACC_W-1:0]   acc;
  logic [WIDTH-1:0]   rem;
  logic [CNT_W-1:0]   cnt;

  logic               in_sa;
  logic               in_sb;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [ACC_W-1:0]   prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               fix_dz;

  // Operand sign/magnitude; unsigned ops (op[0]=1) pass raw values through.
  assign in_sa = ~op[0] & a[WIDTH-1];
  assign in_sb = ~op[0] & b[WIDTH-1];
  assign abs_a = in_sa ? -a : a;
  assign abs_b = in_sb ? -b : b;

  assign busy      = (state != IDLE);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Shift-add step: add multiplicand into the upper half when multiplier LSB is set.
  assign mul_sum = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);

  // Restoring divide step: dividend bits shift out of acc, quotient bits shift in.
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mag_b});
  assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, mag_b}) : div_shift[WIDTH-1:0];

  // Sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    prod   = acc;
    fix_hi = '0;
    fix_lo = '0;
    fix_dz = 1'b0;
    if (op_div) begin
      if (mag_b == '0) begin
        fix_lo = '1;
        fix_hi = sign_a ? -mag_a : mag_a;
        fix_dz = 1'b1;
      end else begin
        fix_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi = sign_a ? -rem : rem;
      end
    end else begin
      prod   = (sign_a ^ sign_b) ? -acc : acc;
      fix_hi = prod[ACC_W-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result write-back and direct HI/LO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_div <= op[1];
            sign_a <= in_sa;
            sign_b <= in_sb;
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            acc    <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            rem    <= '0;
            cnt    <= '0;
            dz     <= 1'b0;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (op_div) begin
            rem            <= div_rem;
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          dz   <= fix_dz;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Parametrised multi-cycle multiply/divide unit that executes the signed and unsigned MULT/DIV families alongside the single-cycle ALU. It owns the HI/LO result registers. The datapath issues an operation with a one-cycle start pulse and stalls while busy is high. It also services direct HI/LO writes (mthi/mtlo).

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  issue pulse; sampled only in IDLE
op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  in  WIDTH  operand A: multiplicand or dividend
b  in  WIDTH  operand B: multiplier or divisor
hi_we  in  1  write wdata to HI; honoured only in IDLE
lo_we  in  1  write wdata to LO; honoured only in IDLE
wdata  in  WIDTH  data for hi_we/lo_we
busy  out  1  high while state is CALC or FIX
done  out  1  one-cycle pulse when a new result is in HI/LO
dz  out  1  divide-by-zero flag, valid with done
hi  out  WIDTH  HI register (MULT: upper product; DIV: remainder)
lo  out  WIDTH  LO register (MULT: lower product; DIV: quotient)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE, busy=0, done=0, dz=0, hi=0, lo=0, counter=0. A reset mid-operation abandons the operation; there is no done and HI/LO read 0.
- FSM IDLE -> CALC -> FIX -> IDLE. busy is decoded from the state.
- IDLE, start=1 at edge k:
  - latch op, sign(a), sign(b), |a|, |b|.
  - Magnitudes are taken only for signed ops; unsigned ops use the raw values.
  - |MIN| = 2^(WIDTH-1) is held as an unsigned WIDTH-bit value.
  - clear the accumulator and counter; go to CALC.
- CALC: one radix-2 iteration per edge, at edges k+1..k+WIDTH.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring division with a WIDTH+1-bit partial remainder.
  - After WIDTH iterations go to FIX.
- FIX at edge k+WIDTH+1:
  - Sign correction: product negated if sign(a)^sign(b); quotient negated if sign(a)^sign(b); remainder takes the sign of a. All results wrap modulo 2^WIDTH.
  - Write hi/lo, set done=1, go to IDLE.
- Timing after FIX: done is high for exactly the cycle after edge k+WIDTH+1, with hi/lo already valid and busy=0. Total latency is WIDTH+1 edges after the start edge; for WIDTH=32, done appears after edge k+33.
- Divide by zero (b==0, DIV or DIVU): latency unchanged; FIX forces lo={WIDTH{1}}, hi=a (raw), dz=1 with done. dz is cleared on the next start.
- Signed overflow MIN/-1: lo=MIN, hi=0 (natural wrap), dz=0.
- start while busy: ignored, no queueing.
- start in the same cycle as done: accepted, since state is IDLE.
- hi_we/lo_we:
  - In IDLE without start: write on that edge. Both may be asserted together.
  - While busy: ignored.
  - In IDLE together with start: start wins and the writes are discarded.
- op values are fully decoded; no illegal encodings exist.
- HI/LO hold their value between operations. A pending operation does not change them until FIX.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, WIDTH=32 -> busy high for 33 cycles; done pulse after edge k+33; hi=0xFFFFFFFE, lo=0x00000001, dz=0.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); then MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=2 -> lo=3, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5 b=0 -> done at normal latency with lo=0xFFFFFFFF, hi=5, dz=1; the following MULTU 2*3 clears dz and gives hi=0, lo=6.
- Handshake: start re-asserted every cycle during an operation -> exactly one done per accepted start. Back-to-back start on the done cycle is accepted. hi_we with wdata=0x1234 while busy -> HI unchanged; the same write in IDLE -> hi=0x1234. Start plus lo_we in IDLE -> lo shows the op result.
- reset asserted at cycle 10 of DIVU 100/7 -> next cycle busy=0, hi=lo=0, no done pulse; a new DIVU 100/7 then gives lo=14, hi=2.
